wnd_arb: RTL and testbench
==========================

# wnd_arb

Frame-level arbiter that shares one window-generator/corner-detector pipeline between the two camera pixel streams. It grants the pipeline to one camera for a whole frame, forwards that camera's pixel/line-valid/frame-valid with one register stage, and enforces an inter-frame flush gap so the downstream window's row count and row buffers reset. Frames whose start falls while the pipeline is busy are dropped and counted. An optional check masks lines whose horizontal blanking is too short for the window's post-row shift-out.

## Interface
- MIN_HBLANK, 8: minimum lv-low cycles required before a line (window COLS+1).
- GAP, 4: forced fv-low cycles on the output after each granted frame.
- DROP_W, 8: width of the per-camera dropped-frame counters.

- c  in  1  clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- p0, p1  in  8 each  camera 0/1 pixel byte.
- lv0, lv1  in  1 each  camera 0/1 line-valid.
- fv0, fv1  in  1 each  camera 0/1 frame-valid.
- en  in  2  per-camera enable; bit k gates new grants to camera k.
- clr  in  1  synchronous clear of drop counters.
- p  out  8  pixel to window block.
- lv  out  1  line-valid to window block.
- fv  out  1  frame-valid to window block.
- sel  out  1  camera currently or last granted.
- busy  out  1  state is GRANT or FLUSH.
- hb_err  out  1  one-cycle pulse: line masked for short blanking.
- drop0, drop1  out  DROP_W each  saturating dropped-frame counts.

## Operation
- Rising fv per camera detected with a registered copy: start_k = fvk & ~fvk_d1 & en[k].
- States: IDLE, GRANT, FLUSH.
- IDLE: if exactly one start_k, grant k (sel<=k), enter GRANT. If both, grant the camera not equal to current sel (round-robin); the other counts as dropped. No start: stay.
- Mid-frame join forbidden: a camera whose fv is already high in IDLE is not granted until its next rising edge.
- GRANT: forward selected camera. When selected fv samples 0, enter FLUSH.
- FLUSH: GAP cycles with p=0, lv=0, fv=0, then IDLE.
- Any start_k of a camera not being forwarded, in GRANT or FLUSH (or the losing side of a tie), increments dropk by 1, saturating at all-ones.
- clr zeroes both counters; a simultaneous drop increment is lost (clr wins).
- en deasserted during GRANT: current frame completes; only new grants are gated.
- Output lv forced 0 whenever output fv is 0.
- Reset mid-frame: state IDLE, all outputs 0; a camera already in-frame waits for its next fv rise.

## Timing
- Reset values: p=0, lv=0, fv=0, sel=0, busy=0, hb_err=0, drop0=drop1=0.
- Latency: 1 cycle. Start at cycle N in IDLE -> fv=1, p/lv = camera values of N, at N+1; busy=1 at N+1.
- Selected fv low at cycle M -> output fv=0 at M+1; FLUSH for cycles M+1..M+GAP; IDLE at M+GAP+1; earliest accepted start sampled at M+GAP+1.
- Start coinciding with the fv-falling cycle M of the granted camera (other camera) is dropped.
- Counters update the cycle after the start edge.

## Configuration
- WND_ARB_HBLANK_CHECK_EN defined: in GRANT a counter of consecutive selected lv-low cycles saturates at MIN_HBLANK, clears on lv high, and is preset to MIN_HBLANK at grant (first line never flagged). If lv rises with count < MIN_HBLANK, that entire line (until lv falls) outputs lv=0, p=0; hb_err pulses 1 cycle, coincident with the output cycle of the masked line's first pixel.
- Undefined: no counter; hb_err tied 0; all lines forwarded unchanged.

## Test plan
- Camera 0 frame, 3 lines of 16 px, 10-cycle blanking -> output identical to input delayed 1 cycle, busy high through flush, fv low exactly GAP=4 cycles after frame.
- fv0 and fv1 rise same cycle after reset (sel=0) -> camera 1 granted, drop0=1, drop1=0; next simultaneous rise grants camera 0, drop1=1.
- Camera 1 rises 3 cycles after camera 0 frame ends -> dropped, drop1 increments; rise at M+GAP+1 -> granted.
- 300 dropped frames with DROP_W=8 -> drop counter holds 255; clr pulse -> 0 next cycle.
- (WND_ARB_HBLANK_CHECK_EN) second line after 5-cycle blanking -> that line's lv stays 0, one hb_err pulse; third line after 8 cycles forwarded.
- rst asserted mid-line in GRANT -> outputs 0 immediately; camera 0 still in frame not regranted until next fv rise.

Source files
------------

// File: rtl/wnd_arb.sv
// wnd_arb -- frame-level arbiter sharing one window/corner pipeline between
// two camera pixel streams.
//
// A camera is granted for a whole frame on the rising edge of its fv. The
// granted stream is forwarded through one register stage. After the frame
// ends, the output is held at fv=0 for GAP cycles so the downstream window
// resets its row count and row buffers. Frame starts that arrive while the
// pipeline is busy, or that lose a simultaneous-start tie, are dropped and
// counted.
//
// Parameters:
//   MIN_HBLANK  minimum lv-low cycles required before a line
//   GAP         forced fv-low cycles after each granted frame
//   DROP_W      width of the saturating dropped-frame counters
//
// Ports:
//   c, rst            clock (rising edge); asynchronous active-high reset
//   p0/lv0/fv0        camera 0 pixel, line-valid, frame-valid
//   p1/lv1/fv1        camera 1 pixel, line-valid, frame-valid
//   en[1:0]           per-camera grant enable (gates new grants only)
//   clr               synchronous clear of both drop counters
//   p/lv/fv           forwarded stream to the window block
//   sel               camera currently or last granted
//   busy              high in GRANT or FLUSH
//   hb_err            one-cycle pulse when a line is masked for short blanking
//   drop0/drop1       saturating dropped-frame counts
//
// Optional feature macro: WND_ARB_HBLANK_CHECK_EN enables masking of lines
// whose preceding horizontal blanking is shorter than MIN_HBLANK.

module wnd_arb #(
  parameter int MIN_HBLANK = 8,
  parameter int GAP        = 4,
  parameter int DROP_W     = 8
) (
  input  logic              c,
  input  logic              rst,
  input  logic [7:0]        p0,
  input  logic [7:0]        p1,
  input  logic              lv0,
  input  logic              lv1,
  input  logic              fv0,
  input  logic              fv1,
  input  logic [1:0]        en,
  input  logic              clr,
  output logic [7:0]        p,
  output logic              lv,
  output logic              fv,
  output logic              sel,
  output logic              busy,
  output logic              hb_err,
  output logic [DROP_W-1:0] drop0,
  output logic [DROP_W-1:0] drop1
);

  typedef enum logic [1:0] {IDLE, GRANT, FLUSH} state_t;

  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  state_t        state;
  logic [GW-1:0] gcnt;
  logic [1:0]    fv_d;
  logic [1:0]    start;
  logic          nsel;
  logic          cur;
  logic [7:0]    p_c, p_f;
  logic          lv_c, lv_f, fv_c;
  logic          inc0, inc1;

  // fv_d resets to 1 so a camera already mid-frame when reset drops does
  // not look like a fresh frame start; it must show a real low->high edge.
  assign start = {fv1, fv0} & ~fv_d & en;

  // On a tie the camera that is not the current sel wins (round-robin).
  assign nsel = (start == 2'b11) ? ~sel : start[1];

  // Camera being looked at this cycle: the one about to be granted in IDLE,
  // otherwise the one already granted.
  assign cur  = (state == IDLE) ? nsel : sel;
  assign p_c  = cur ? p1  : p0;
  assign lv_c = cur ? lv1 : lv0;
  assign fv_c = cur ? fv1 : fv0;

  // Drops: any start while busy, or the tie loser (the camera equal to sel).
  assign inc0 = start[0] & ((state != IDLE) | (start[1] & ~sel));
  assign inc1 = start[1] & ((state != IDLE) | (start[0] &  sel));

`ifdef WND_ARB_HBLANK_CHECK_EN
  localparam int HW = $clog2(MIN_HBLANK + 1);

  logic [HW-1:0] hb_cnt, hb_cnt_n;
  logic          mask, mask_n, short_n, rise;

  // hb_cnt counts consecutive lv-low cycles and is cleared by lv high, so a
  // non-zero count with lv high marks the first pixel of a new line.
  always_comb begin
    rise     = lv_c & (hb_cnt != '0);
    short_n  = rise & (hb_cnt < HW'(MIN_HBLANK));
    mask_n   = lv_c & (rise ? short_n : mask);
    hb_cnt_n = lv_c ? '0 :
               (hb_cnt == HW'(MIN_HBLANK)) ? hb_cnt : hb_cnt + 1'b1;
    lv_f     = lv_c & ~mask_n;
    p_f      = mask_n ? 8'h00 : p_c;
  end

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      hb_cnt <= '0;
      mask   <= 1'b0;
      hb_err <= 1'b0;
    end else begin
      hb_err <= 1'b0;
      if (state == IDLE) begin
        // Preset so the first line of a frame is never flagged.
        hb_cnt <= HW'(MIN_HBLANK);
        mask   <= 1'b0;
      end else if (state == GRANT && fv_c) begin
        hb_cnt <= hb_cnt_n;
        mask   <= mask_n;
        hb_err <= short_n;
      end
    end
  end
`else
  assign lv_f   = lv_c;
  assign p_f    = p_c;
  assign hb_err = 1'b0;
`endif

  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gcnt  <= '0;
      fv_d  <= 2'b11;
      sel   <= 1'b0;
      busy  <= 1'b0;
      fv    <= 1'b0;
      lv    <= 1'b0;
      p     <= 8'h00;
    end else begin
      fv_d <= {fv1, fv0};
      unique case (state)
        IDLE: begin
          if (|start) begin
            state <= GRANT;
            busy  <= 1'b1;
            sel   <= nsel;
            fv    <= 1'b1;
            lv    <= lv_f;
            p     <= p_f;
          end
        end
        GRANT: begin
          if (fv_c) begin
            lv <= lv_f;
            p  <= p_f;
          end else begin
            state <= FLUSH;
            gcnt  <= GW'(GAP - 1);
            fv    <= 1'b0;
            lv    <= 1'b0;
            p     <= 8'h00;
          end
        end
        FLUSH: begin
          if (gcnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gcnt <= gcnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // clr has priority over a same-cycle increment.
  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      drop0 <= '0;
      drop1 <= '0;
    end else if (clr) begin
      drop0 <= '0;
      drop1 <= '0;
    end else begin
      if (inc0 && drop0 != '1) drop0 <= drop0 + 1'b1;
      if (inc1 && drop1 != '1) drop1 <= drop1 + 1'b1;
    end
  end

endmodule

// File: tb/tb_wnd_arb.sv
module tb_wnd_arb;
  localparam int GAP = 4;
`ifdef WND_ARB_HBLANK_CHECK_EN
  localparam bit HB = 1'b1;
`else
  localparam bit HB = 1'b0;
`endif

  logic       c = 1'b0;
  logic       rst;
  logic [7:0] p0, p1;
  logic       lv0, lv1, fv0, fv1;
  logic [1:0] en;
  logic       clr;
  logic [7:0] p;
  logic       lv, fv, sel, busy, hb_err;
  logic [7:0] drop0, drop1;

  int checks = 0;
  int errors = 0;

  wnd_arb #(.MIN_HBLANK(8), .GAP(GAP), .DROP_W(8)) dut (
    .c(c), .rst(rst), .p0(p0), .p1(p1), .lv0(lv0), .lv1(lv1),
    .fv0(fv0), .fv1(fv1), .en(en), .clr(clr), .p(p), .lv(lv), .fv(fv),
    .sel(sel), .busy(busy), .hb_err(hb_err), .drop0(drop0), .drop1(drop1)
  );

  always #5 c = ~c;

  // Advance one clock; outputs then reflect the inputs sampled at that edge.
  task automatic step;
    @(posedge c);
    #1;
  endtask

  // Drop both streams and wait out the flush so the arbiter is IDLE.
  task automatic end_frame;
    fv0 = 0; fv1 = 0; lv0 = 0; lv1 = 0; p0 = 0; p1 = 0;
    repeat (GAP + 1) step;
  endtask

  task automatic test_reset;
    rst = 1; p0 = 0; p1 = 0; lv0 = 0; lv1 = 0; fv0 = 0; fv1 = 0;
    en = 2'b11; clr = 0;
    repeat (2) step;
    checks++;
    if ({p, lv, fv, sel, busy, hb_err} !== 13'h0 || drop0 !== 0 || drop1 !== 0) begin
      errors++;
      $display("FAIL reset_hold: p=%h lv=%b fv=%b sel=%b busy=%b hb=%b d0=%0d d1=%0d want all 0",
               p, lv, fv, sel, busy, hb_err, drop0, drop1);
    end
    @(negedge c) rst = 0;
    step;
    checks++;
    if ({p, lv, fv, sel, busy, hb_err} !== 13'h0) begin
      errors++;
      $display("FAIL reset_release: p=%h lv=%b fv=%b sel=%b busy=%b want all 0", p, lv, fv, sel, busy);
    end
  endtask

  task automatic test_frame;
    for (int ln = 0; ln < 3; ln++) begin
      for (int i = 0; i < 26; i++) begin
        fv0 = 1;
        lv0 = (i >= 10);
        p0  = (i >= 10) ? 8'(ln * 16 + i - 10) : 8'hA5;
        step;
        checks++;
        if (fv !== 1'b1 || lv !== lv0 || p !== p0 || busy !== 1'b1 || sel !== 1'b0) begin
          errors++;
          $display("FAIL frame ln%0d i%0d: fv=%b lv=%b p=%h busy=%b sel=%b want 1 %b %h 1 0",
                   ln, i, fv, lv, p, busy, sel, lv0, p0);
        end
      end
    end
    fv0 = 0; lv0 = 0; p0 = 8'h3C;
    for (int k = 1; k <= GAP + 1; k++) begin
      step;
      checks++;
      if (fv !== 1'b0 || lv !== 1'b0 || p !== 8'h00 || busy !== (k <= GAP)) begin
        errors++;
        $display("FAIL flush k%0d: fv=%b lv=%b p=%h busy=%b want 0 0 00 %b",
                 k, fv, lv, p, busy, (k <= GAP));
      end
    end
  endtask

  task automatic test_tie;
    fv0 = 1; fv1 = 1; p0 = 8'h11; p1 = 8'h22; lv0 = 0; lv1 = 1;
    step;
    checks++;
    if (sel !== 1'b1 || fv !== 1'b1 || p !== 8'h22 || lv !== 1'b1 || drop0 !== 8'd1 || drop1 !== 8'd0) begin
      errors++;
      $display("FAIL tie1: sel=%b fv=%b p=%h lv=%b d0=%0d d1=%0d want 1 1 22 1 1 0",
               sel, fv, p, lv, drop0, drop1);
    end
    fv0 = 0; fv1 = 0; lv1 = 0;
    repeat (GAP + 1) step;
    fv0 = 1; fv1 = 1; p0 = 8'h33; p1 = 8'h44; lv0 = 1;
    step;
    checks++;
    if (sel !== 1'b0 || p !== 8'h33 || lv !== 1'b1 || drop0 !== 8'd1 || drop1 !== 8'd1) begin
      errors++;
      $display("FAIL tie2: sel=%b p=%h lv=%b d0=%0d d1=%0d want 0 33 1 1 1", sel, p, lv, drop0, drop1);
    end
    end_frame;
  endtask

  task automatic test_drop_window;
    fv0 = 1; lv0 = 1; p0 = 8'h01;
    step; step;
    fv0 = 0; lv0 = 0;                  // cycle M
    step; step; step;                  // now in M+3
    fv1 = 1;
    step;
    checks++;
    if (drop1 !== 8'd2 || busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_drop: d1=%0d busy=%b want 2 1", drop1, busy);
    end
    fv1 = 0;
    step;                              // now in M+5
    fv1 = 1; lv1 = 1; p1 = 8'h5A;
    step;
    checks++;
    if (sel !== 1'b1 || fv !== 1'b1 || p !== 8'h5A || lv !== 1'b1 || busy !== 1'b1 || drop1 !== 8'd2) begin
      errors++;
      $display("FAIL gap_grant: sel=%b fv=%b p=%h lv=%b busy=%b d1=%0d want 1 1 5a 1 1 2",
               sel, fv, p, lv, busy, drop1);
    end
    // camera 0 rises on the very cycle camera 1's frame ends
    fv1 = 0; lv1 = 0; fv0 = 1;
    step;
    checks++;
    if (fv !== 1'b0 || drop0 !== 8'd2) begin
      errors++;
      $display("FAIL fall_drop: fv=%b d0=%0d want 0 2", fv, drop0);
    end
    repeat (GAP + 2) step;
    checks++;
    if (busy !== 1'b0 || fv !== 1'b0) begin
      errors++;
      $display("FAIL no_midjoin: busy=%b fv=%b want 0 0", busy, fv);
    end
    fv0 = 0;
    step;
  endtask

  task automatic test_enable;
    en = 2'b01; fv1 = 1;
    step;
    checks++;
    if (busy !== 1'b0 || drop1 !== 8'd2) begin
      errors++;
      $display("FAIL en_gate: busy=%b d1=%0d want 0 2", busy, drop1);
    end
    en = 2'b11;
    step; step;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL en_midjoin: busy=%b want 0", busy);
    end
    fv1 = 0;
    step;
  endtask

  task automatic test_saturate;
    fv0 = 1;
    step;
    for (int i = 0; i < 300; i++) begin
      fv1 = 1; step;
      fv1 = 0; step;
    end
    checks++;
    if (drop1 !== 8'd255 || busy !== 1'b1 || sel !== 1'b0) begin
      errors++;
      $display("FAIL saturate: d1=%0d busy=%b sel=%b want 255 1 0", drop1, busy, sel);
    end
    clr = 1; fv1 = 1;
    step;
    checks++;
    if (drop1 !== 8'd0 || drop0 !== 8'd0) begin
      errors++;
      $display("FAIL clr_wins: d0=%0d d1=%0d want 0 0", drop0, drop1);
    end
    clr = 0; fv1 = 0;
    step;
    fv1 = 1;
    step;
    checks++;
    if (drop1 !== 8'd1) begin
      errors++;
      $display("FAIL after_clr: d1=%0d want 1", drop1);
    end
    end_frame;
  endtask

  task automatic test_hblank;
    int len [6] = '{10, 4, 5, 4, 8, 4};
    logic       msk, ex_lv, ex_hb;
    logic [7:0] ex_p;
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < len[s]; i++) begin
        fv0 = 1;
        lv0 = s[0];
        p0  = s[0] ? 8'(8'hA0 + s * 8 + i) : 8'h00;
        msk   = HB && (s == 3);
        ex_lv = lv0 & ~msk;
        ex_p  = msk ? 8'h00 : p0;
        ex_hb = msk && (i == 0);
        step;
        checks++;
        if (lv !== ex_lv || p !== ex_p || hb_err !== ex_hb || fv !== 1'b1) begin
          errors++;
          $display("FAIL hblank s%0d i%0d: lv=%b p=%h hb=%b fv=%b want %b %h %b 1",
                   s, i, lv, p, hb_err, fv, ex_lv, ex_p, ex_hb);
        end
      end
    end
    end_frame;
  endtask

  task automatic test_reset_mid;
    fv0 = 1; lv0 = 0; p0 = 8'h00;
    step;
    lv0 = 1; p0 = 8'h77;
    step;
    #2 rst = 1;
    #1;
    checks++;
    if ({p, lv, fv, sel, busy, hb_err} !== 13'h0 || drop0 !== 0 || drop1 !== 0) begin
      errors++;
      $display("FAIL reset_mid: p=%h lv=%b fv=%b sel=%b busy=%b d0=%0d d1=%0d want all 0",
               p, lv, fv, sel, busy, drop0, drop1);
    end
    @(negedge c) rst = 0;
    repeat (3) step;
    checks++;
    if (busy !== 1'b0 || fv !== 1'b0) begin
      errors++;
      $display("FAIL reset_nojoin: busy=%b fv=%b want 0 0", busy, fv);
    end
    fv0 = 0;
    step;
    fv0 = 1;
    step;
    checks++;
    if (busy !== 1'b1 || fv !== 1'b1 || sel !== 1'b0 || p !== 8'h77 || lv !== 1'b1) begin
      errors++;
      $display("FAIL reset_regrant: busy=%b fv=%b sel=%b p=%h lv=%b want 1 1 0 77 1",
               busy, fv, sel, p, lv);
    end
    end_frame;
  endtask

  initial begin
    test_reset;
    test_frame;
    test_tie;
    test_drop_window;
    test_enable;
    test_saturate;
    test_hblank;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
